// File: rtl/noc_packetizer_pkg.sv
// noc_packetizer_pkg
// Shared definitions for the NoC injection packetizer: default widths,
// flit and header field offsets (at the default widths), and the FSM
// state encoding.
package noc_packetizer_pkg;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_X_W    = 4;
  localparam int DEF_Y_W    = 4;
  localparam int DEF_PCK_W  = 8;

  // Flit layout, LSB first: data, pck_num, dest_x, dest_y
  localparam int DATA_LSB = 0;
  localparam int PCK_LSB  = DATA_LSB + DEF_DATA_W;
  localparam int X_LSB    = PCK_LSB + DEF_PCK_W;
  localparam int Y_LSB    = X_LSB + DEF_X_W;

  // Header word layout, LSB first: dest_x, dest_y, len
  localparam int HDR_X_LSB   = 0;
  localparam int HDR_Y_LSB   = HDR_X_LSB + DEF_X_W;
  localparam int HDR_LEN_LSB = HDR_Y_LSB + DEF_Y_W;
  localparam int HDR_LEN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/noc_packetizer_flit_out_reg.sv
// noc_packetizer_flit_out_reg
// One-entry valid/ready pipeline register holding the outgoing flit.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          capture load_data and raise valid (wins over clear)
//   load_data     flit to capture
//   out_ready     downstream ready; clears valid on handshake
//   valid, data   registered flit toward the injection FIFO
module noc_packetizer_flit_out_reg #(
  parameter int W = 272
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Valid flag: set on load, cleared on handshake, otherwise held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Flit payload: only changes on load so it stays stable during a stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/noc_packetizer.sv
// noc_packetizer
// Turns a scheduler word stream (one header, then len payload words) into
// NoC flits {dest_y, dest_x, pck_num, data}, one per payload word.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_valid, i_data   scheduler word in; o_ready accepts it
//   o_valid, o_data   flit out; i_ready is the injection FIFO ready
//   o_busy            a packet is in progress
//   o_done            one-cycle pulse after the last flit (or a len=0 header)
module noc_packetizer
  import noc_packetizer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int PCK_W  = DEF_PCK_W,
  parameter int TOT_W  = Y_W + X_W + PCK_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [TOT_W-1:0]  o_data,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  // Header offsets recomputed from the actual parameters
  localparam int LEN_LSB = X_W + Y_W;

  pkt_state_e           state_r;
  logic [X_W-1:0]       dest_x_r;
  logic [Y_W-1:0]       dest_y_r;
  logic [PCK_W-1:0]     pck_r;
  logic [HDR_LEN_W-1:0] rem_r;
  logic                 done_r;

  logic                 ready_s;
  logic                 in_acc_s;
  logic                 out_hs_s;
  logic                 load_s;
  logic [HDR_LEN_W-1:0] hdr_len_s;
  logic [TOT_W-1:0]     flit_s;

  assign hdr_len_s = i_data[LEN_LSB +: HDR_LEN_W];
  assign in_acc_s  = i_valid && ready_s;
  assign out_hs_s  = o_valid && i_ready;
  assign load_s    = (state_r == ST_PAYLOAD) && in_acc_s;
  assign flit_s    = {dest_y_r, dest_x_r, pck_r, i_data};

  // Input ready by state; in PAYLOAD it passes downstream ready through so
  // a handshake and a new load can share a cycle
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE:    ready_s = 1'b1;
      ST_PAYLOAD: ready_s = !o_valid || i_ready;
      ST_DRAIN:   ready_s = 1'b0;
      default:    ready_s = 1'b0;
    endcase
  end

  // Packet FSM: header decode, payload counting, drain of the last flit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      dest_x_r <= '0;
      dest_y_r <= '0;
      pck_r    <= '0;
      rem_r    <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_acc_s) begin
            dest_x_r <= i_data[HDR_X_LSB +: X_W];
            dest_y_r <= i_data[X_W +: Y_W];
            rem_r    <= hdr_len_s;
            pck_r    <= '0;
            if (hdr_len_s == 16'd0) begin
              done_r <= 1'b1;
            end else begin
              state_r <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (in_acc_s) begin
            pck_r <= pck_r + PCK_W'(1);
            rem_r <= rem_r - 16'd1;
            if (rem_r == 16'd1) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The last flit already sits in the output register
          if (out_hs_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  noc_packetizer_flit_out_reg #(
    .W (TOT_W)
  ) u_flit_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (flit_s),
    .out_ready (i_ready),
    .valid     (o_valid),
    .data      (o_data)
  );

  assign o_ready = ready_s;
  assign o_busy  = (state_r != ST_IDLE);
  assign o_done  = done_r;

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer
// Self-checking bench: a per-cycle vector table for a basic packet, then
// packet-level sequences checked against a flit scoreboard built from the
// header/payload rules (stall, len=0, pck_num wrap, mid-packet reset,
// random valid/ready toggling).
module tb_noc_packetizer;

  localparam int DW = 256;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int PW = 8;
  localparam int TW = YW + XW + PW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_ready;
  logic          o_valid;
  logic [TW-1:0] o_data;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  noc_packetizer dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int n_flits = 0;

  // Scoreboard state
  logic [TW-1:0] exp_q[$];
  bit            last_q[$];
  bit            exp_done_next = 1'b0;
  bit            busy_exp = 1'b0;
  bit            prev_stall = 1'b0;
  logic [TW-1:0] prev_data = '0;
  int            cur_len = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ir;
    logic          ov;
    logic [TW-1:0] od;
    logic          ordy;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_flit(input int x, input int y, input int pck, input logic [DW-1:0] d);
    logic [TW-1:0] f;
    f = {y[YW-1:0], x[XW-1:0], pck[PW-1:0], d};
    return f;
  endfunction

  function automatic logic [DW-1:0] mk_hdr(input int x, input int y, input int len);
    logic [DW-1:0] h;
    h = '0;
    h[3:0]  = x[3:0];
    h[7:4]  = y[3:0];
    h[23:8] = len[15:0];
    return h;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One cycle: drive at the falling edge, check, predict, cross the rising edge
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit ir,
                      input bit is_hdr, output bit acc);
    bit out_hs;
    bit lst;
    i_valid = iv;
    i_data  = d;
    i_ready = ir;
    #1;
    check("done", TW'(o_done), TW'(exp_done_next));
    check("busy", TW'(o_busy), TW'(busy_exp));
    if (prev_stall) begin
      check("hold_valid", TW'(o_valid), TW'(1'b1));
      check("hold_data", o_data, prev_data);
    end
    if (!busy_exp) check("ready_idle", TW'(o_ready), TW'(1'b1));
    else if (o_valid && !ir) check("ready_stall", TW'(o_ready), TW'(1'b0));
    acc    = iv && o_ready;
    out_hs = o_valid && ir;
    exp_done_next = 1'b0;
    if (out_hs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flit", o_data, '0);
      end else begin
        check("flit", o_data, exp_q.pop_front());
        lst = last_q.pop_front();
        n_flits++;
        if (lst) begin
          exp_done_next = 1'b1;
          busy_exp = 1'b0;
        end
      end
    end
    if (acc && is_hdr) begin
      if (cur_len == 0) exp_done_next = 1'b1;
      else busy_exp = 1'b1;
    end
    prev_stall = o_valid && !ir;
    prev_data  = o_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void push_pkt(input int x, input int y, input int len,
                                   input logic [DW-1:0] pl[$]);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(mk_flit(x, y, k % (1 << PW), pl[k]));
      last_q.push_back(k == len - 1);
    end
  endfunction

  task automatic run_packet(input int x, input int y, input int len, input bit rnd,
                            input bit fixed, input int stall_len);
    logic [DW-1:0] words[$];
    logic [DW-1:0] pl[$];
    int idx;
    int cyc;
    int limit;
    int start;
    int stall_left;
    bit iv;
    bit ir;
    bit acc;
    cur_len = len;
    for (int k = 0; k < len; k++) pl.push_back(fixed ? DW'(32'hA + k) : rnd_word());
    words.push_back(mk_hdr(x, y, len));
    for (int k = 0; k < len; k++) words.push_back(pl[k]);
    push_pkt(x, y, len, pl);
    start = n_flits;
    stall_left = stall_len;
    idx = 0;
    cyc = 0;
    limit = 20 * len + 100;
    while ((idx < words.size() || exp_q.size() != 0) && cyc < limit) begin
      iv = rnd ? bit'($urandom_range(1, 0)) : 1'b1;
      if (idx >= words.size()) iv = 1'b0;
      ir = rnd ? bit'($urandom_range(1, 0)) : 1'b1;
      if (stall_left > 0 && o_valid) begin
        ir = 1'b0;
        stall_left--;
      end
      step(iv, (idx < words.size()) ? words[idx] : rnd_word(), ir, idx == 0, acc);
      if (acc) idx++;
      cyc++;
    end
    if (cyc >= limit) check("pkt_timeout", TW'(cyc), TW'(limit - 1));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check("flit_count", TW'(n_flits - start), TW'(len));
  endtask

  initial begin
    logic [DW-1:0] h;
    logic [DW-1:0] pl[$];
    bit acc;

    // Table vectors: header x=2,y=1,len=3 then payloads A,B,C, i_ready=1
    h = mk_hdr(2, 1, 3);
    tbl[0] = '{1'b1, h,        1'b1, 1'b0, '0,                    1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, DW'('hA), 1'b1, 1'b0, '0,                    1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, DW'('hB), 1'b1, 1'b1, mk_flit(2, 1, 0, 'hA), 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, DW'('hC), 1'b1, 1'b1, mk_flit(2, 1, 1, 'hB), 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, '0,       1'b1, 1'b1, mk_flit(2, 1, 2, 'hC), 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, '0,       1'b1, 1'b0, '0,                    1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, '0,       1'b1, 1'b0, '0,                    1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", TW'(o_valid), TW'(1'b0));
    check("rst_data", o_data, '0);
    check("rst_busy", TW'(o_busy), TW'(1'b0));
    check("rst_done", TW'(o_done), TW'(1'b0));
    check("rst_ready", TW'(o_ready), TW'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      i_valid = tbl[r].iv;
      i_data  = tbl[r].d;
      i_ready = tbl[r].ir;
      #1;
      check($sformatf("tbl%0d_valid", r), TW'(o_valid), TW'(tbl[r].ov));
      if (tbl[r].ov) check($sformatf("tbl%0d_data", r), o_data, tbl[r].od);
      check($sformatf("tbl%0d_ready", r), TW'(o_ready), TW'(tbl[r].ordy));
      check($sformatf("tbl%0d_busy", r), TW'(o_busy), TW'(tbl[r].busy));
      check($sformatf("tbl%0d_done", r), TW'(o_done), TW'(tbl[r].done));
      @(negedge clk);
    end

    // Stall: i_ready low 5 cycles once the first flit is presented
    run_packet(2, 1, 3, 1'b0, 1'b1, 5);

    // len=0 header: no flit, done next cycle, next header accepted at once
    cur_len = 0;
    step(1'b1, mk_hdr(5, 6, 0), 1'b1, 1'b1, acc);
    check("len0_acc", TW'(acc), TW'(1'b1));
    check("len0_novalid", TW'(o_valid), TW'(1'b0));
    check("len0_ready", TW'(o_ready), TW'(1'b1));
    run_packet(7, 9, 2, 1'b0, 1'b0, 0);

    // pck_num wrap
    run_packet(1, 4, 300, 1'b0, 1'b0, 0);

    // Reset in the middle of a 4-flit packet
    cur_len = 4;
    pl.delete();
    for (int k = 0; k < 4; k++) pl.push_back(rnd_word());
    push_pkt(1, 1, 4, pl);
    step(1'b1, mk_hdr(1, 1, 4), 1'b1, 1'b1, acc);
    for (int k = 0; k < 3; k++) step(1'b1, pl[k], 1'b1, 1'b0, acc);
    check("mid_valid", TW'(o_valid), TW'(1'b1));
    check("mid_flits", TW'(n_flits), TW'(3 + 2 + 300 + 2));
    i_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", TW'(o_valid), TW'(1'b0));
    check("arst_busy", TW'(o_busy), TW'(1'b0));
    check("arst_done", TW'(o_done), TW'(1'b0));
    check("arst_ready", TW'(o_ready), TW'(1'b1));
    exp_q.delete();
    last_q.delete();
    busy_exp = 1'b0;
    exp_done_next = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_packet(3, 3, 1, 1'b0, 1'b0, 0);

    // Random valid/ready toggling
    run_packet(5, 2, 64, 1'b1, 1'b0, 0);
    for (int p = 0; p < 4; p++) begin
      run_packet($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(20, 1),
                 1'b1, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
